// File: rtl/axi_rback_pkg.sv
// Shared definitions for the readback read-burst engine: AXI burst/response codes,
// the engine state encoding and the skid FIFO entry layout.
package axi_rback_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Cycles from ren to valid dev_rdata.
  localparam int RBACK_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEL,
    S_READ,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

endpackage

// File: rtl/axi_rback_burst_rd_skid_fifo.sv
// Small registered-output FIFO holding R beats (data, resp, last) between the
// fixed-latency device pipe and the backpressured R channel.
module rback_skid_fifo
  import axi_rback_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                axi_clk,
  input  logic                arst,
  input  logic                push_i,
  input  rbeat_t              push_data_i,
  input  logic                pop_i,
  output rbeat_t              head_o,
  output logic                valid_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  rbeat_t                mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge axi_clk) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset as well, so the R outputs read 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/axi_rback_burst_rd.sv
// AXI3-subset read burst engine for the readback stores: AR accept, device addressing,
// fixed-latency data capture and R skid buffering. Define RBACK_WRAP_BURST_EN for WRAP bursts.
module axi_rback_burst_rd
  import axi_rback_pkg::*;
#(
  parameter int AXI_RD_ADDR_BITS = 14,
  parameter int RBACK_DEPTH      = 11,
  parameter int FIFO_DEPTH_LOG2  = 2,
  parameter int ID_WIDTH         = 12
) (
  input  logic                        axi_clk,
  input  logic                        arst,
  input  logic [AXI_RD_ADDR_BITS-1:0] araddr,
  input  logic [ID_WIDTH-1:0]         arid,
  input  logic [3:0]                  arlen,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [31:0]                 rdata,
  output logic [ID_WIDTH-1:0]         rid,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [AXI_RD_ADDR_BITS-1:0] pre_araddr,
  output logic                        start_burst,
  output logic [RBACK_DEPTH-1:0]      raddr,
  output logic                        ren,
  input  logic [31:0]                 dev_rdata,
  input  logic                        dev_selected,
  output logic                        busy
);

  localparam int FIFO_ENTRIES = 1 << FIFO_DEPTH_LOG2;

  state_e                      state_q, state_d;
  logic [AXI_RD_ADDR_BITS-1:0] addr_q;
  logic [ID_WIDTH-1:0]         id_q;
  logic [3:0]                  len_q;
  logic [1:0]                  burst_q;
  logic                        sel_q;
  logic [3:0]                  issued_q, pushed_q;
  logic [RBACK_DEPTH-1:0]      raddr_q;
  logic [RBACK_RD_LATENCY-1:0] ren_pipe_q;

  logic                        ar_hs, push, room;
  logic [3:0]                  next_beat;
  logic [RBACK_DEPTH-1:0]      base_lo, incr_addr, next_addr;
  logic [FIFO_DEPTH_LOG2:0]    fifo_count;
  rbeat_t                      push_beat, head;

  assign ar_hs = arvalid && arready;
  assign push  = ren_pipe_q[RBACK_RD_LATENCY-1];
  // Anything already requested from the devices still needs a FIFO slot.
  assign room  = (int'(fifo_count) + $countones(ren_pipe_q)) < FIFO_ENTRIES;

`ifdef RBACK_WRAP_BURST_EN
  logic [RBACK_DEPTH-1:0] wrap_mask;
  logic                   wrap_ok;
  assign wrap_mask = RBACK_DEPTH'(len_q);
  assign wrap_ok   = (burst_q == BURST_WRAP) && (len_q inside {4'd1, 4'd3, 4'd7, 4'd15});
`endif

  // raddr_q always holds the address of the next beat to be requested.
  assign next_beat = (state_q == S_SEL) ? 4'd0 : issued_q + 4'd1;

  always_comb begin
    base_lo   = addr_q[RBACK_DEPTH-1:0];
    incr_addr = base_lo + RBACK_DEPTH'(next_beat);
    next_addr = (burst_q == BURST_FIXED) ? base_lo : incr_addr;
`ifdef RBACK_WRAP_BURST_EN
    if (wrap_ok) next_addr = (base_lo & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
  end

  always_ff @(posedge axi_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arvalid) state_d = S_START;
      S_START: state_d = S_SEL;
      S_SEL:   state_d = S_READ;
      S_READ:  if (ren && (issued_q == len_q)) state_d = S_DRAIN;
      S_DRAIN: if (rvalid && rready && rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    arready     = 1'b0;
    start_burst = 1'b0;
    busy        = 1'b1;
    ren         = 1'b0;
    case (state_q)
      S_IDLE: begin
        arready = 1'b1;
        busy    = 1'b0;
      end
      S_START: start_burst = 1'b1;
      S_READ:  ren = room;
      default: ;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (arst) begin
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      sel_q      <= 1'b0;
      issued_q   <= '0;
      pushed_q   <= '0;
      raddr_q    <= '0;
      ren_pipe_q <= '0;
    end else begin
      if (ar_hs) begin
        addr_q  <= araddr;
        id_q    <= arid;
        len_q   <= arlen;
        burst_q <= arburst;
      end
      if (state_q == S_SEL) begin
        sel_q    <= dev_selected;
        raddr_q  <= next_addr;
        issued_q <= '0;
        pushed_q <= '0;
      end else begin
        if (ren) begin
          raddr_q  <= next_addr;
          issued_q <= issued_q + 4'd1;
        end
        if (push) pushed_q <= pushed_q + 4'd1;
      end
      ren_pipe_q <= {ren_pipe_q[RBACK_RD_LATENCY-2:0], ren};
    end
  end

  // An unclaimed burst still returns every beat, zeroed and flagged SLVERR.
  always_comb begin
    push_beat.data = sel_q ? dev_rdata : 32'd0;
    push_beat.resp = sel_q ? RESP_OKAY : RESP_SLVERR;
    push_beat.last = (pushed_q == len_q);
  end

  rback_skid_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .axi_clk     (axi_clk),
    .arst        (arst),
    .push_i      (push),
    .push_data_i (push_beat),
    .pop_i       (rready),
    .head_o      (head),
    .valid_o     (rvalid),
    .count_o     (fifo_count)
  );

  assign rdata      = head.data;
  assign rresp      = head.resp;
  assign rlast      = head.last && rvalid;
  assign rid        = id_q;
  assign raddr      = raddr_q;
  assign pre_araddr = addr_q;

endmodule

// File: tb/tb_axi_rback_burst_rd.sv
// Directed plus randomized bench for axi_rback_burst_rd with a behavioural burst
// model and a 2-cycle readback device model.
`timescale 1ns/1ps
module tb_axi_rback_burst_rd;

  localparam int AW = 14;
  localparam int RD = 11;
  localparam int IW = 12;

  logic          axi_clk = 1'b0;
  logic          arst;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [3:0]    arlen;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [31:0]   rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [AW-1:0] pre_araddr;
  logic          start_burst;
  logic [RD-1:0] raddr;
  logic          ren;
  logic [31:0]   dev_rdata = '0;
  logic          dev_selected;
  logic          busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [31:0]   dev_salt = '0;
  logic          dev_ren_p1 = 1'b0;
  logic [RD-1:0] dev_addr_p1 = '0;

  always #5 axi_clk = ~axi_clk;

  axi_rback_burst_rd dut (
    .axi_clk      (axi_clk),
    .arst         (arst),
    .araddr       (araddr),
    .arid         (arid),
    .arlen        (arlen),
    .arburst      (arburst),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rid          (rid),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .pre_araddr   (pre_araddr),
    .start_burst  (start_burst),
    .raddr        (raddr),
    .ren          (ren),
    .dev_rdata    (dev_rdata),
    .dev_selected (dev_selected),
    .busy         (busy)
  );

  function automatic logic [31:0] dev_word(input logic [RD-1:0] a);
    return dev_salt ^ ({21'd0, a} * 32'h9E37_79B1);
  endfunction

  // Readback device: data for a ren appears two cycles later, garbage otherwise.
  always @(posedge axi_clk) begin
    dev_ren_p1  <= ren;
    dev_addr_p1 <= raddr;
    dev_rdata   <= dev_ren_p1 ? dev_word(dev_addr_p1) : 32'hDEAD_BEEF;
  end

  // Device word address of beat i, straight from the AXI burst rules.
  function automatic logic [RD-1:0] exp_addr(input logic [AW-1:0] base, input logic [1:0] bt,
                                             input int len, input int i);
    int a;
    a = int'(base) + i;
    if (bt == 2'b00) a = int'(base);
`ifdef RBACK_WRAP_BURST_EN
    if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15))
      a = (int'(base) / (len + 1)) * (len + 1) + ((int'(base) % (len + 1) + i) % (len + 1));
`endif
    if (i > len) a = 0;
    return a[RD-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge. rmode: 0 always ready, 1 one-on/three-off, 2 random.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [3:0] len,
                           input logic [1:0] bt, input logic sel, input int rmode, input int abort_at,
                           input logic hold_next, input logic [IW-1:0] next_id, input string tag);
    int            nb       = int'(len) + 1;
    int            issued   = 0;
    int            popped   = 0;
    int            k        = 0;
    int            first_rv = -1;
    bit            done     = 1'b0;
    bit            aborted  = 1'b0;
    bit            stalled  = 1'b0;
    bit            hs;
    logic [31:0]   held_data = '0;
    logic [RD-1:0] ea [16];

    dev_salt     = $urandom;
    dev_selected = sel;
    for (int i = 0; i < nb; i++) ea[i] = exp_addr(addr, bt, int'(len), i);
    araddr  = addr;
    arid    = id;
    arlen   = len;
    arburst = bt;
    arvalid = 1'b1;
    while (arready !== 1'b1 && k < 100) begin
      @(negedge axi_clk);
      k++;
    end
    if (arready !== 1'b1) begin
      check({tag, "_ar_timeout"}, arready, 1);
      arvalid = 1'b0;
      return;
    end
    @(negedge axi_clk);
    if (hold_next) arid = next_id;
    else           arvalid = 1'b0;

    k = 1;
    while (!done && k <= 300) begin
      check({tag, "_start_burst"}, start_burst, k == 1);
      check({tag, "_arready_busy"}, arready, 0);
      if (k == 1) begin
        check({tag, "_pre_araddr"}, pre_araddr, addr);
        check({tag, "_busy"}, busy, 1);
      end
      if (ren) begin
        check({tag, "_ren_early"}, k >= 3, 1);
        check({tag, "_ren_count"}, issued < nb, 1);
        check({tag, "_overflow"}, (issued - popped) < 4, 1);
        if (issued < nb) check({tag, "_raddr"}, raddr, ea[issued]);
        issued++;
      end
      if (stalled) begin
        check({tag, "_stall_rvalid"}, rvalid, 1);
        check({tag, "_stall_rdata"}, rdata, held_data);
      end
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = (k % 4 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      hs        = rvalid && rready;
      stalled   = rvalid && !rready;
      held_data = rdata;
      if (rvalid) begin
        if (first_rv < 0) first_rv = k;
        if (popped < nb) begin
          check({tag, "_rdata"}, rdata, sel ? dev_word(ea[popped]) : 32'd0);
          check({tag, "_rresp"}, rresp, sel ? 2'b00 : 2'b10);
          check({tag, "_rlast"}, rlast, popped == nb - 1);
          check({tag, "_rid"}, rid, id);
        end else begin
          check({tag, "_extra_beat"}, rvalid, 0);
        end
      end
      if (hs) begin
        popped++;
        if (popped == nb) done = 1'b1;
      end
      if (abort_at >= 0 && hs && popped == abort_at) begin
        arst    = 1'b1;
        aborted = 1'b1;
        done    = 1'b1;
      end
      @(negedge axi_clk);
      k++;
    end

    if (aborted) begin
      check({tag, "_rst_rvalid"}, rvalid, 0);
      check({tag, "_rst_ren"}, ren, 0);
      check({tag, "_rst_arready"}, arready, 1);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_rlast"}, rlast, 0);
      arst = 1'b0;
      return;
    end
    check({tag, "_beats"}, popped, nb);
    check({tag, "_issued"}, issued, nb);
    check({tag, "_arready_after"}, arready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_rvalid_after"}, rvalid, 0);
    if (rmode == 0) begin
      check({tag, "_first_rvalid"}, first_rv, 6);
      check({tag, "_last_cycle"}, k - 1, 5 + nb);
    end
  endtask

  initial begin
    arst         = 1'b1;
    arvalid      = 1'b0;
    araddr       = '0;
    arid         = '0;
    arlen        = '0;
    arburst      = '0;
    rready       = 1'b0;
    dev_selected = 1'b0;
    repeat (3) @(negedge axi_clk);

    check("reset_arready", arready, 1);
    check("reset_rvalid", rvalid, 0);
    check("reset_rlast", rlast, 0);
    check("reset_start_burst", start_burst, 0);
    check("reset_ren", ren, 0);
    check("reset_busy", busy, 0);
    check("reset_rdata", rdata, 0);
    check("reset_rid", rid, 0);
    check("reset_rresp", rresp, 0);
    check("reset_raddr", raddr, 0);
    check("reset_pre_araddr", pre_araddr, 0);
    arst = 1'b0;
    @(negedge axi_clk);
    check("idle_arready", arready, 1);

    run_burst(14'h0005, 12'h0AA, 4'd0,  2'b01, 1'b1, 0, -1, 1'b0, 12'h000, "single");
    run_burst(14'h07F8, 12'h123, 4'd15, 2'b01, 1'b1, 0, -1, 1'b0, 12'h000, "incr16");
    run_burst(14'h0100, 12'h456, 4'd15, 2'b01, 1'b1, 1, -1, 1'b0, 12'h000, "backpressure");
    run_burst(14'h0040, 12'h789, 4'd3,  2'b01, 1'b0, 0, -1, 1'b0, 12'h000, "unselected");
    run_burst(14'h0200, 12'h001, 4'd7,  2'b01, 1'b1, 0, -1, 1'b1, 12'h002, "b2b_first");
    run_burst(14'h0200, 12'h002, 4'd7,  2'b01, 1'b1, 0, -1, 1'b0, 12'h000, "b2b_second");
    run_burst(14'h0300, 12'h0BB, 4'd15, 2'b01, 1'b1, 0,  5, 1'b0, 12'h000, "abort");
    run_burst(14'h0310, 12'h0CC, 4'd15, 2'b01, 1'b1, 2, -1, 1'b0, 12'h000, "after_abort");
    run_burst(14'h0123, 12'h0DD, 4'd3,  2'b00, 1'b1, 1, -1, 1'b0, 12'h000, "fixed");
    run_burst(14'h0006, 12'h0EE, 4'd3,  2'b10, 1'b1, 0, -1, 1'b0, 12'h000, "wrap4");
    run_burst(14'h3FFE, 12'h0FF, 4'd7,  2'b11, 1'b1, 2, -1, 1'b0, 12'h000, "reserved");

    for (int n = 0; n < 12; n++) begin
      run_burst(AW'($urandom), IW'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) != 0, $urandom_range(0, 2), -1, 1'b0, 12'h000, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
